// File: rtl/philv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : philv_pkg                                                   |
// | Description : Shared encodings for the PhilosophyV execute stage: ALU     |
// |               operation codes, funct3 branch/load codes, load opcode.     |
// | Config      : none (PHILV_XEDGCOL_EN is consumed by philv_exec_unit)      |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package philv_pkg;

  localparam int ALU_FUNCT_WIDTH = 4;

  // ALU operation codes (bit 3 distinguishes SUB/SRA from ADD/SRL)
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_ADD  = 4'b0000;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_SUB  = 4'b1000;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_SLL  = 4'b0001;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_SLT  = 4'b0010;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_SLTU = 4'b0011;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_XOR  = 4'b0100;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_SRL  = 4'b0101;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_SRA  = 4'b1101;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_OR   = 4'b0110;
  localparam logic [ALU_FUNCT_WIDTH-1:0] C_ALU_AND  = 4'b0111;

  // Branch conditions (funct3)
  localparam logic [2:0] C_BR_BEQ  = 3'b000;
  localparam logic [2:0] C_BR_BNE  = 3'b001;
  localparam logic [2:0] C_BR_BLT  = 3'b100;
  localparam logic [2:0] C_BR_BGE  = 3'b101;
  localparam logic [2:0] C_BR_BLTU = 3'b110;
  localparam logic [2:0] C_BR_BGEU = 3'b111;

  // Load widths (funct3)
  localparam logic [2:0] C_LD_LB  = 3'b000;
  localparam logic [2:0] C_LD_LH  = 3'b001;
  localparam logic [2:0] C_LD_LW  = 3'b010;
  localparam logic [2:0] C_LD_LBU = 3'b100;
  localparam logic [2:0] C_LD_LHU = 3'b101;

  localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

endpackage
`default_nettype wire

// File: rtl/philv_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : philv_alu                                                   |
// | Description : Pure combinational RV32I integer ALU.                       |
// | Ports       : alu_funct [in]  operation code                              |
// |               x, y      [in]  operands A and B                            |
// |               z         [out] result (0 for unused codes)                 |
// |               equal     [out] x == y, independent of alu_funct            |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module philv_alu
  import philv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  output logic [N-1:0]               z,
  output logic                       equal
);

  logic [4:0] w_shamt;
  logic       w_lt_signed;
  logic       w_lt_unsigned;

  assign w_shamt       = y[4:0];
  assign w_lt_signed   = ($signed(x) < $signed(y));
  assign w_lt_unsigned = (x < y);
  assign equal         = (x == y);

  always_comb begin
    z = '0;
    case (alu_funct)
      C_ALU_ADD:  z = x + y;
      C_ALU_SUB:  z = x - y;
      C_ALU_SLL:  z = x << w_shamt;
      C_ALU_SLT:  z = {{(N-1){1'b0}}, w_lt_signed};
      C_ALU_SLTU: z = {{(N-1){1'b0}}, w_lt_unsigned};
      C_ALU_XOR:  z = x ^ y;
      C_ALU_SRL:  z = x >> w_shamt;
      C_ALU_SRA:  z = $unsigned($signed(x) >>> w_shamt);
      C_ALU_OR:   z = x | y;
      C_ALU_AND:  z = x & y;
      default:    z = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/philv_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : philv_exec_unit                                             |
// | Description : PhilosophyV execute stage: ALU, branch resolution, load     |
// |               data extension and the registered execute result.          |
// | Config      : PHILV_XEDGCOL_EN adds coll_lo/exec_sel and an input mux on  |
// |               the result register.                                       |
// | Ports       : clk, rstb (async, active low)                               |
// |               alu_funct, x, y           ALU controls/operands             |
// |               funct3, opcode            branch and load selection         |
// |               mem_rd_data               aligned word from data memory     |
// |               coll_lo, exec_sel         accelerator result (optional)     |
// |               z, equal, branch          combinational ALU/branch outputs  |
// |               load_data                 combinational extended load data  |
// |               ex_out                    registered execute result         |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module philv_exec_unit
  import philv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 opcode,
  input  logic [N-1:0]               mem_rd_data,
`ifdef PHILV_XEDGCOL_EN
  input  logic [N-1:0]               coll_lo,
  input  logic                       exec_sel,
`endif
  output logic [N-1:0]               z,
  output logic                       equal,
  output logic                       branch,
  output logic [N-1:0]               ex_out,
  output logic [N-1:0]               load_data
);

  logic [N-1:0] ex_out_d;
  logic [N-1:0] ex_out_q;

  philv_alu #(
    .N (N)
  ) u_alu (
    .alu_funct (alu_funct),
    .x         (x),
    .y         (y),
    .z         (z),
    .equal     (equal)
  );

  // Relational branches rely on the controller having selected SLT/SLTU,
  // so the compare outcome is already sitting in z[0].
  always_comb begin
    branch = 1'b0;
    case (funct3)
      C_BR_BEQ:              branch = equal;
      C_BR_BNE:              branch = ~equal;
      C_BR_BLT,  C_BR_BLTU:  branch = z[0];
      C_BR_BGE,  C_BR_BGEU:  branch = ~z[0];
      default:               branch = 1'b0;
    endcase
  end

  always_comb begin
    load_data = mem_rd_data;
    if (opcode == OPCODE_LOAD) begin
      case (funct3)
        C_LD_LB:  load_data = {{(N-8){mem_rd_data[7]}}, mem_rd_data[7:0]};
        C_LD_LH:  load_data = {{(N-16){mem_rd_data[15]}}, mem_rd_data[15:0]};
        C_LD_LW:  load_data = mem_rd_data;
        C_LD_LBU: load_data = {{(N-8){1'b0}}, mem_rd_data[7:0]};
        C_LD_LHU: load_data = {{(N-16){1'b0}}, mem_rd_data[15:0]};
        default:  load_data = mem_rd_data;
      endcase
    end
  end

`ifdef PHILV_XEDGCOL_EN
  assign ex_out_d = exec_sel ? coll_lo : z;
`else
  assign ex_out_d = z;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ex_out_q <= '0;
    end else begin
      ex_out_q <= ex_out_d;
    end
  end

  assign ex_out = ex_out_q;

endmodule
`default_nettype wire

// File: tb/tb_philv_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_philv_exec_unit                                          |
// | Description : Self-checking bench for philv_exec_unit: directed vector    |
// |               table, random stimulus against a reference model, reset     |
// |               and optional accelerator-mux sequences.                     |
// | Config      : PHILV_XEDGCOL_EN enables the accelerator-mux sequence.      |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_philv_exec_unit;

  logic        clk;
  logic        rstb;
  logic [3:0]  alu_funct;
  logic [31:0] x;
  logic [31:0] y;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic [31:0] mem_rd_data;
`ifdef PHILV_XEDGCOL_EN
  logic [31:0] coll_lo;
  logic        exec_sel;
`endif
  logic [31:0] z;
  logic        equal;
  logic        branch;
  logic [31:0] ex_out;
  logic [31:0] load_data;

  int checks;
  int errors;

  philv_exec_unit #(.N(32)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .alu_funct   (alu_funct),
    .x           (x),
    .y           (y),
    .funct3      (funct3),
    .opcode      (opcode),
    .mem_rd_data (mem_rd_data),
`ifdef PHILV_XEDGCOL_EN
    .coll_lo     (coll_lo),
    .exec_sel    (exec_sel),
`endif
    .z           (z),
    .equal       (equal),
    .branch      (branch),
    .ex_out      (ex_out),
    .load_data   (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] mem;
    logic [31:0] ez;
    logic        eeq;
    logic        ebr;
    logic [31:0] eld;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (arithmetic formulation) ----------------
  function automatic longint to_signed(input logic [31:0] v);
    return v[31] ? (longint'(v) - 64'sh1_0000_0000) : longint'(v);
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    longint unsigned pw;
    longint unsigned ua;
    longint unsigned ub;
    pw = 64'd1 << (b % 32);
    ua = a;
    ub = b;
    case (f)
      4'b0000: return 32'((ua + ub) % 64'h1_0000_0000);
      4'b1000: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      4'b0001: return 32'((ua * pw) % 64'h1_0000_0000);
      4'b0010: return (to_signed(a) < to_signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (ua < ub) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return 32'(ua / pw);
      4'b1101: return a[31] ? ~32'((~ua & 64'hFFFF_FFFF) / pw) : 32'(ua / pw);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_branch(input logic [2:0] f3, input logic eq, input logic [31:0] zz);
    case (f3)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return zz[0];
      3'b101, 3'b111: return !zz[0];
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] m);
    longint unsigned v;
    if (op != 7'b0000011) return m;
    case (f3)
      3'b000: begin v = m % 256;   if (v >= 128)   v = v + 64'hFFFF_FF00; return 32'(v); end
      3'b001: begin v = m % 65536; if (v >= 32768) v = v + 64'hFFFF_0000; return 32'(v); end
      3'b100: return 32'(m % 256);
      3'b101: return 32'(m % 65536);
      default: return m;
    endcase
  endfunction

  // Drive one vector at the falling edge, check the combinational outputs,
  // then check the registered result one rising edge later.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    alu_funct   = v.f;
    x           = v.a;
    y           = v.b;
    funct3      = v.f3;
    opcode      = v.op;
    mem_rd_data = v.mem;
    #1;
    check({tag, " z"},         z,                 v.ez);
    check({tag, " equal"},     {31'd0, equal},    {31'd0, v.eeq});
    check({tag, " branch"},    {31'd0, branch},   {31'd0, v.ebr});
    check({tag, " load_data"}, load_data,         v.eld);
    @(posedge clk);
    #1;
    check({tag, " ex_out"},    ex_out,            v.ez);
  endtask

  function automatic vec_t mk(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] f3, input logic [6:0] op, input logic [31:0] mem,
                              input logic [31:0] ez, input logic eeq, input logic ebr,
                              input logic [31:0] eld);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.f3 = f3; v.op = op; v.mem = mem;
    v.ez = ez; v.eeq = eeq; v.ebr = ebr; v.eld = eld;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [3:0] codes [10];
    checks = 0;
    errors = 0;
    codes = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

    // Directed table: ALU edge cases, branch decode, load extension.
    tbl.push_back(mk(4'b1000, 32'h8000_0000, 32'd1, 3'b000, 7'h33, 32'hA5A5_A5A5, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'hA5A5_A5A5));
    tbl.push_back(mk(4'b0010, 32'h8000_0000, 32'd1, 3'b100, 7'h33, 32'hA5A5_A5A5, 32'd1,         1'b0, 1'b1, 32'hA5A5_A5A5));
    tbl.push_back(mk(4'b0011, 32'h8000_0000, 32'd1, 3'b110, 7'h33, 32'hA5A5_A5A5, 32'd0,         1'b0, 1'b0, 32'hA5A5_A5A5));
    tbl.push_back(mk(4'b1101, 32'h8000_0000, 32'd4, 3'b010, 7'h33, 32'h0,         32'hF800_0000, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(4'b0101, 32'h8000_0000, 32'd4, 3'b011, 7'h33, 32'h0,         32'h0800_0000, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(4'b1111, 32'h8000_0000, 32'd4, 3'b101, 7'h33, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(4'b0000, 32'd7,         32'd7, 3'b000, 7'h33, 32'h0,         32'd14,        1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(4'b0000, 32'd7,         32'd7, 3'b001, 7'h33, 32'h0,         32'd14,        1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(4'b0010, 32'hFFFF_FFFF, 32'd1, 3'b100, 7'h33, 32'h0,         32'd1,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(4'b0011, 32'hFFFF_FFFF, 32'd1, 3'b111, 7'h33, 32'h0,         32'd0,         1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(4'b0011, 32'hFFFF_FFFF, 32'd1, 3'b010, 7'h33, 32'h0,         32'd0,         1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(4'b0000, 32'd0, 32'd0, 3'b000, 7'h03, 32'h1234_80F0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFF0));
    tbl.push_back(mk(4'b0000, 32'd0, 32'd0, 3'b100, 7'h03, 32'h1234_80F0, 32'd0, 1'b1, 1'b0, 32'h0000_00F0));
    tbl.push_back(mk(4'b0000, 32'd0, 32'd0, 3'b001, 7'h03, 32'h1234_80F0, 32'd0, 1'b1, 1'b0, 32'hFFFF_80F0));
    tbl.push_back(mk(4'b0000, 32'd0, 32'd0, 3'b101, 7'h03, 32'h1234_80F0, 32'd0, 1'b1, 1'b1, 32'h0000_80F0));
    tbl.push_back(mk(4'b0000, 32'd0, 32'd0, 3'b010, 7'h03, 32'h1234_80F0, 32'd0, 1'b1, 1'b0, 32'h1234_80F0));
    tbl.push_back(mk(4'b0000, 32'd0, 32'd0, 3'b011, 7'h03, 32'h1234_80F0, 32'd0, 1'b1, 1'b0, 32'h1234_80F0));
    tbl.push_back(mk(4'b0000, 32'd0, 32'd0, 3'b000, 7'h33, 32'h1234_80F0, 32'd0, 1'b1, 1'b1, 32'h1234_80F0));
    tbl.push_back(mk(4'b0000, 32'hFFFF_FFFF, 32'd1, 3'b001, 7'h33, 32'h0, 32'd0, 1'b0, 1'b1, 32'h0));
    tbl.push_back(mk(4'b0001, 32'd1,    32'h25,   3'b011, 7'h33, 32'h0, 32'h20,   1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(4'b0100, 32'hF0F0, 32'hFF00, 3'b011, 7'h33, 32'h0, 32'h0FF0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(4'b0110, 32'hF0F0, 32'hFF00, 3'b011, 7'h33, 32'h0, 32'hFFF0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(4'b0111, 32'hF0F0, 32'hFF00, 3'b011, 7'h33, 32'h0, 32'hF000, 1'b0, 1'b0, 32'h0));

    // Reset state
    rstb        = 1'b0;
    alu_funct   = 4'b0000;
    x           = 32'd1;
    y           = 32'd2;
    funct3      = 3'b000;
    opcode      = 7'h33;
    mem_rd_data = 32'h0;
`ifdef PHILV_XEDGCOL_EN
    coll_lo     = 32'h0;
    exec_sel    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset ex_out", ex_out, 32'd0);
    @(negedge clk);
    rstb = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Random stimulus against the model
    for (int i = 0; i < 200; i++) begin
      v.f   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 9)];
      v.a   = $urandom;
      v.b   = ($urandom_range(0, 7) == 0) ? v.a : $urandom;
      v.f3  = 3'($urandom);
      v.op  = ($urandom_range(0, 1) == 0) ? 7'b0000011 : 7'($urandom);
      v.mem = $urandom;
      v.ez  = m_alu(v.f, v.a, v.b);
      v.eeq = (v.a == v.b);
      v.ebr = m_branch(v.f3, v.eeq, v.ez);
      v.eld = m_load(v.op, v.f3, v.mem);
      apply(v, $sformatf("rnd%0d", i));
    end

    // Mid-run asynchronous reset
    apply(mk(4'b0000, 32'd5, 32'd6, 3'b011, 7'h33, 32'h0, 32'd11, 1'b0, 1'b0, 32'h0), "pre_reset");
    #2;
    rstb = 1'b0;
    #1;
    check("async reset clears ex_out", ex_out, 32'd0);
    @(posedge clk);
    #1;
    check("ex_out held in reset", ex_out, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    apply(mk(4'b0000, 32'd5, 32'd3, 3'b011, 7'h33, 32'h0, 32'd8, 1'b0, 1'b0, 32'h0), "post_reset");

`ifdef PHILV_XEDGCOL_EN
    @(negedge clk);
    exec_sel  = 1'b1;
    coll_lo   = 32'hDEAD_BEEF;
    alu_funct = 4'b0000;
    x         = 32'd1;
    y         = 32'd2;
    @(posedge clk);
    #1;
    check("ex_out from coll_lo", ex_out, 32'hDEAD_BEEF);
    @(negedge clk);
    exec_sel = 1'b0;
    @(posedge clk);
    #1;
    check("ex_out back to z", ex_out, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/philv_exec_unit.md
# philv_exec_unit

Execute-stage datapath block of the PhilosophyV multicycle RV32I core. It contains three parts:
- a combinational integer ALU;
- branch-condition resolution derived from the ALU result;
- load-data extraction and extension for data-memory reads.

It also holds the execute-stage result register. It sits between the register-file/operand muxes and the memory stage, and feeds the PC logic and data-memory address.

## Interface
- N, 32: datapath width in bits.
- clk  in  1  single clock; everything samples on its rising edge.
- rstb  in  1  asynchronous, active-low reset.
- alu_funct  in  4  ALU operation code.
- x  in  N  ALU operand A.
- y  in  N  ALU operand B.
- funct3  in  3  instruction funct3; selects the branch condition and the load width.
- opcode  in  7  instruction opcode.
- mem_rd_data  in  N  raw word read from data memory.
- coll_lo  in  N  accelerator result word. Present only with PHILV_XEDGCOL_EN.
- exec_sel  in  1  1 = register coll_lo, 0 = register the ALU result. Present only with PHILV_XEDGCOL_EN.
- z  out  N  combinational ALU result.
- equal  out  1  combinational, x == y.
- branch  out  1  combinational branch-taken flag.
- ex_out  out  N  registered execute result.
- load_data  out  N  combinational extended load data.

## Operation
ALU encodings for alu_funct. All arithmetic wraps modulo 2^N. Shift amount is y[4:0].
- 0000 ADD
- 1000 SUB
- 0001 SLL
- 0010 SLT (signed; result is 1 or 0)
- 0011 SLTU (unsigned; result is 1 or 0)
- 0100 XOR
- 0101 SRL
- 1101 SRA (arithmetic)
- 0110 OR
- 0111 AND
- Every other code gives z = 0.
- equal is independent of alu_funct.

Branch flag, decoded from funct3. The controller has already programmed SLT for signed compares and SLTU for unsigned compares.
- 000 BEQ: branch = equal.
- 001 BNE: branch = !equal.
- 100 BLT and 110 BLTU: branch = z[0].
- 101 BGE and 111 BGEU: branch = !z[0].
- 010, 011: branch = 0.

Load data extraction applies when opcode = 0000011. Selection uses mem_rd_data, which memory has already aligned.
- LB (000): sign-extend [7:0].
- LH (001): sign-extend [15:0].
- LW (010): full word.
- LBU (100): zero-extend [7:0].
- LHU (101): zero-extend [15:0].
- Other funct3 values: pass-through.

For any opcode other than load, load_data = mem_rd_data.

## Timing
- z, equal, branch and load_data are purely combinational, with zero latency.
- ex_out is loaded on every rising clk edge; there is no enable. It takes the ALU result, or coll_lo when the configuration option is enabled and exec_sel = 1.
- Latency from an operand change to ex_out is one cycle.
- rstb low asynchronously clears ex_out to 0. The register holds 0 while rstb is low.
- Loading resumes on the first rising edge after rstb deasserts.
- Combinational outputs are unaffected by reset.

## Configuration
- PHILV_XEDGCOL_EN defined: the coll_lo and exec_sel ports exist, and the ex_out input mux is built.
- PHILV_XEDGCOL_EN undefined: those ports are absent, and ex_out always registers z.

## Structure
- Shared package philv_pkg holds:
  - ALU_FUNCT_WIDTH and the alu_funct localparams;
  - the funct3 branch and load codes;
  - OPCODE_LOAD.
- One natural sub-module: philv_alu, the pure combinational ALU (z and equal).
- Branch decode and load extension are inline always_comb logic.
- The result register is in the top-level block.

## Test plan
- Reset: assert rstb = 0 mid-run -> ex_out = 0 immediately, without waiting for an edge. After release, x = 5, y = 3, ADD -> ex_out = 8 one cycle later.
- ALU arithmetic: x = 0x80000000, y = 1.
  - SUB -> 0x7FFFFFFF.
  - SLT -> 1.
  - SLTU -> 0.
  - Then y = 4: SRA -> 0xF8000000, SRL -> 0x08000000.
  - Undefined code 1111 -> 0.
- Branch:
  - x = y = 7, funct3 = 000 -> branch = 1.
  - funct3 = 001 -> 0.
  - x = -1, y = 1 with SLT and funct3 = 100 -> 1.
  - Same operands with SLTU and funct3 = 111 -> 1.
  - funct3 = 010 -> 0.
- Loads: opcode = 0000011, mem_rd_data = 0x1234_80F0.
  - LB -> 0xFFFFFFF0.
  - LBU -> 0xF0.
  - LH -> 0xFFFF80F0.
  - LHU -> 0x80F0.
  - LW -> unchanged.
  - opcode = 0110011 -> unchanged.
- Wrap-around: 0xFFFFFFFF ADD 1 -> z = 0, equal = 0.
- With PHILV_XEDGCOL_EN: exec_sel = 1, coll_lo = 0xDEADBEEF -> ex_out = 0xDEADBEEF next cycle. Setting exec_sel = 0 returns ex_out to z.
